fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the control unit: owns the PC register, issues

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit_next_pc.sv | 35 +++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch slice.
//   word_t        : 32-bit machine word used for addresses and instructions
//   pc_src_t      : next-PC select driven by the control unit
//   fetch_state_t : fetch FSM states
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REG    = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    REQ  = 2'b00,
    HOLD = 2'b01,
    HALT = 2'b10
  } fetch_state_t;

  // Sign-extend a 16-bit branch offset and turn it into a byte offset.
  function automatic word_t branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's bus signals: instruction-memory port and the
// control/decode handshake.
//   master : fetch_unit side (drives imem request and the latched instruction)
//   slave  : environment side (memory, control unit, register file)
interface fetch_unit_if;
  import cpu_types_pkg::*;

  // control / register-file inputs to fetch
  pc_src_t     PC_src;
  logic        PC_EN;
  logic        halt;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  word_t       rs_data;

  // instruction memory port
  logic        ihit;
  word_t       imemload;
  logic        imemREN;
  word_t       imemaddr;

  // to decode / control
  word_t       instr;
  logic        instr_valid;
  word_t       pc;
  word_t       pc_plus4;
  logic        halted;

  modport master (
    input  PC_src, PC_EN, halt, imm16, jaddr, rs_data, ihit, imemload,
    output imemREN, imemaddr, instr, instr_valid, pc, pc_plus4, halted
  );

  modport slave (
    output PC_src, PC_EN, halt, imm16, jaddr, rs_data, ihit, imemload,
    input  imemREN, imemaddr, instr, instr_valid, pc, pc_plus4, halted
  );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// next_pc_calc: combinational next-PC selection.
//   pc       in  current PC
//   pc_src   in  select: PC+4, branch, jump, register
//   imm16    in  branch offset (words, signed)
//   jaddr    in  jump target (words)
//   rs_data  in  register value for jr
//   next_pc  out selected next PC (mod 2^32)
//   pc_plus4 out pc + 4
module next_pc_calc
  import cpu_types_pkg::*;
(
  input  word_t       pc,
  input  pc_src_t     pc_src,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  word_t       rs_data,
  output word_t       next_pc,
  output word_t       pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src)
      PC_NEXT:   next_pc = pc_plus4;
      PC_BRANCH: next_pc = pc_plus4 + branch_offset(imm16);
      PC_JUMP:   next_pc = {pc_plus4[31:28], jaddr, 2'b00};
      // Masking keeps the PC word aligned even for a misaligned register.
      PC_REG:    next_pc = rs_data & ~32'h0000_0003;
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, requests instruction
// words, latches the returned word for decode and advances the PC when the
// control unit retires the instruction.
//   CLK   in  system clock
//   nRST  in  asynchronous active-low reset
//   fif   fetch_unit_if.master (imem port, control inputs, decode outputs)
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input logic          CLK,
  input logic          nRST,
  fetch_unit_if.master fif
);

  // The PC is always word aligned, including right after reset.
  localparam word_t PC_RST = {PC_INIT[31:2], 2'b00};

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  word_t        next_pc;
  word_t        pc_plus4;

  next_pc_calc u_next_pc (
    .pc       (pc_q),
    .pc_src   (fif.PC_src),
    .imm16    (fif.imm16),
    .jaddr    (fif.jaddr),
    .rs_data  (fif.rs_data),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= REQ;
      pc_q     <= PC_RST;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    unique case (state_q)
      // Waiting on memory; control inputs are meaningless here.
      REQ: begin
        if (fif.ihit) begin
          instr_d = fif.imemload;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      // Instruction latched; halt takes priority over retiring it.
      HOLD: begin
        if (fif.halt) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (fif.PC_EN) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      HALT: ;
      default: state_d = REQ;
    endcase
  end

  assign fif.imemREN     = (state_q == REQ);
  assign fif.imemaddr    = pc_q;
  assign fif.pc          = pc_q;
  assign fif.pc_plus4    = pc_plus4;
  assign fif.instr       = instr_q;
  assign fif.instr_valid = valid_q;
  assign fif.halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  fetch_unit_if fif ();

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fif  (fif)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_fetch(input word_t w);
    fif.ihit     = 1'b1;
    fif.imemload = w;
    step();
    fif.ihit     = 1'b0;
  endtask

  task automatic do_advance(input pc_src_t src, input logic [15:0] imm,
                            input logic [25:0] ja, input word_t rs);
    fif.PC_src  = src;
    fif.imm16   = imm;
    fif.jaddr   = ja;
    fif.rs_data = rs;
    fif.PC_EN   = 1'b1;
    step();
    fif.PC_EN   = 1'b0;
    fif.PC_src  = PC_NEXT;
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (fif.imemREN !== 1'b1 || fif.pc !== 32'h0 || fif.instr_valid !== 1'b0 ||
        fif.halted !== 1'b0 || fif.instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ren=%b pc=%h valid=%b halted=%b instr=%h, need 1/0/0/0/0",
               fif.imemREN, fif.pc, fif.instr_valid, fif.halted, fif.instr);
    end
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (fif.imemREN !== 1'b1 || fif.imemaddr !== 32'h0 || fif.instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_req[%0d]: ren=%b addr=%h valid=%b, need 1/00000000/0",
                 i, fif.imemREN, fif.imemaddr, fif.instr_valid);
      end
    end
  endtask

  task automatic test_fetch();
    do_fetch(32'h2001_0005);
    checks++;
    if (fif.instr !== 32'h2001_0005 || fif.instr_valid !== 1'b1 || fif.imemREN !== 1'b0) begin
      errors++;
      $display("FAIL fetch_latch: instr=%h valid=%b ren=%b, need 20010005/1/0",
               fif.instr, fif.instr_valid, fif.imemREN);
    end
    checks++;
    if (fif.pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL pc_plus4_0: got %h need 00000004", fif.pc_plus4);
    end
    do_advance(PC_NEXT, 16'h0, 26'h0, 32'h0);
    checks++;
    if (fif.pc !== 32'h4 || fif.imemaddr !== 32'h4 || fif.imemREN !== 1'b1 ||
        fif.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL advance_plus4: pc=%h addr=%h ren=%b valid=%b, need 4/4/1/0",
               fif.pc, fif.imemaddr, fif.imemREN, fif.instr_valid);
    end
  endtask

  task automatic test_branch_jump();
    // pc=4: jump to 0x40 words -> 0x100
    do_fetch(32'h0800_0040);
    do_advance(PC_JUMP, 16'h0, 26'h40, 32'h0);
    checks++;
    if (fif.pc !== 32'h100) begin
      errors++;
      $display("FAIL jump_from_4: pc=%h need 00000100", fif.pc);
    end
    // pc=0x100: branch -2 words -> 0x104 - 8 = 0xFC
    do_fetch(32'h1000_FFFE);
    do_advance(PC_BRANCH, 16'hFFFE, 26'h0, 32'h0);
    checks++;
    if (fif.pc !== 32'h0FC) begin
      errors++;
      $display("FAIL branch_back: pc=%h need 000000fc", fif.pc);
    end
    do_fetch(32'h0800_0040);
    do_advance(PC_JUMP, 16'h0, 26'h40, 32'h0);
    checks++;
    if (fif.pc !== 32'h100) begin
      errors++;
      $display("FAIL jump_0x40: pc=%h need 00000100", fif.pc);
    end
    // forward branch +3 words from 0x100 -> 0x104 + 12 = 0x110
    do_fetch(32'h1000_0003);
    do_advance(PC_BRANCH, 16'h0003, 26'h0, 32'h0);
    checks++;
    if (fif.pc !== 32'h110) begin
      errors++;
      $display("FAIL branch_fwd: pc=%h need 00000110", fif.pc);
    end
  endtask

  task automatic test_reg_wrap();
    do_fetch(32'h03E0_0008);
    do_advance(PC_REG, 16'h0, 26'h0, 32'h0000_0207);
    checks++;
    if (fif.pc !== 32'h204) begin
      errors++;
      $display("FAIL jr_align: pc=%h need 00000204", fif.pc);
    end
    do_fetch(32'h03E0_0008);
    do_advance(PC_REG, 16'h0, 26'h0, 32'hFFFF_FFFF);
    checks++;
    if (fif.pc !== 32'hFFFF_FFFC || fif.pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL jr_top: pc=%h pc_plus4=%h need fffffffc/00000000", fif.pc, fif.pc_plus4);
    end
    // jump keeps pc_plus4[31:28]; here pc_plus4 wrapped to 0
    do_fetch(32'h0000_0000);
    checks++;
    if (fif.pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL hold_pc: pc=%h need fffffffc", fif.pc);
    end
    do_advance(PC_NEXT, 16'h0, 26'h0, 32'h0);
    checks++;
    if (fif.pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_plus4: pc=%h need 00000000", fif.pc);
    end
  endtask

  task automatic test_ignored_inputs();
    // In REQ with no ihit, PC_EN and halt do nothing.
    fif.PC_EN = 1'b1;
    fif.halt  = 1'b1;
    step();
    step();
    fif.PC_EN = 1'b0;
    fif.halt  = 1'b0;
    checks++;
    if (fif.pc !== 32'h0 || fif.imemREN !== 1'b1 || fif.halted !== 1'b0) begin
      errors++;
      $display("FAIL req_ignores_ctrl: pc=%h ren=%b halted=%b need 0/1/0",
               fif.pc, fif.imemREN, fif.halted);
    end
    // In HOLD without PC_EN, a new ihit must not overwrite instr.
    do_fetch(32'hAAAA_5555);
    fif.ihit     = 1'b1;
    fif.imemload = 32'h1234_5678;
    step();
    step();
    fif.ihit = 1'b0;
    checks++;
    if (fif.instr !== 32'hAAAA_5555 || fif.instr_valid !== 1'b1 || fif.pc !== 32'h0 ||
        fif.imemREN !== 1'b0) begin
      errors++;
      $display("FAIL hold_ignores_ihit: instr=%h valid=%b pc=%h ren=%b need aaaa5555/1/0/0",
               fif.instr, fif.instr_valid, fif.pc, fif.imemREN);
    end
    do_advance(PC_JUMP, 16'h0, 26'h123, 32'h0);
    checks++;
    if (fif.pc !== 32'h48C) begin
      errors++;
      $display("FAIL jump_0x123: pc=%h need 0000048c", fif.pc);
    end
  endtask

  task automatic test_halt();
    do_fetch(32'hFFFF_FFFF);
    fif.halt  = 1'b1;
    fif.PC_EN = 1'b1;
    step();
    fif.halt  = 1'b0;
    fif.PC_EN = 1'b0;
    checks++;
    if (fif.halted !== 1'b1 || fif.pc !== 32'h48C || fif.imemREN !== 1'b0 ||
        fif.instr !== 32'hFFFF_FFFF || fif.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL halt_wins: halted=%b pc=%h ren=%b instr=%h valid=%b need 1/48c/0/ffffffff/1",
               fif.halted, fif.pc, fif.imemREN, fif.instr, fif.instr_valid);
    end
    fif.ihit     = 1'b1;
    fif.imemload = 32'h0;
    fif.PC_EN    = 1'b1;
    for (int i = 0; i < 4; i++) step();
    fif.ihit  = 1'b0;
    fif.PC_EN = 1'b0;
    checks++;
    if (fif.halted !== 1'b1 || fif.pc !== 32'h48C || fif.imemREN !== 1'b0 ||
        fif.instr !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL halt_frozen: halted=%b pc=%h ren=%b instr=%h need 1/48c/0/ffffffff",
               fif.halted, fif.pc, fif.imemREN, fif.instr);
    end
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    step();
    checks++;
    if (fif.pc !== 32'h0 || fif.halted !== 1'b0 || fif.imemREN !== 1'b1 ||
        fif.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: pc=%h halted=%b ren=%b valid=%b need 0/0/1/0",
               fif.pc, fif.halted, fif.imemREN, fif.instr_valid);
    end
  endtask

  task automatic test_async_reset();
    do_fetch(32'h2001_0005);
    do_advance(PC_NEXT, 16'h0, 26'h0, 32'h0);
    do_fetch(32'h2002_0006);
    checks++;
    if (fif.pc !== 32'h4 || fif.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_async: pc=%h valid=%b need 4/1", fif.pc, fif.instr_valid);
    end
    // Assert reset between edges; outputs must clear with no clock edge.
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (fif.pc !== 32'h0 || fif.instr !== 32'h0 || fif.instr_valid !== 1'b0 ||
        fif.imemREN !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: pc=%h instr=%h valid=%b ren=%b need 0/0/0/1",
               fif.pc, fif.instr, fif.instr_valid, fif.imemREN);
    end
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    fif.PC_src   = PC_NEXT;
    fif.PC_EN    = 1'b0;
    fif.halt     = 1'b0;
    fif.imm16    = '0;
    fif.jaddr    = '0;
    fif.rs_data  = '0;
    fif.ihit     = 1'b0;
    fif.imemload = '0;
    test_reset();
    test_fetch();
    test_branch_jump();
    test_reg_wrap();
    test_ignored_inputs();
    test_halt();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
